// File: rtl/div_seq_if.sv
// Request/response bundle for the sequential divider: operands and start in,
// busy/done handshake plus quotient, remainder and flags out.
interface div_seq_if #(parameter int width = 6);
  logic                 start;
  logic [2*width-1:0]   a;
  logic [width-1:0]     b;
  logic                 sel;
  logic                 busy;
  logic                 done;
  logic [width-1:0]     q;
  logic [width-1:0]     r;
  logic                 dbz;
  logic                 ovf;

  modport master (output start, a, b, sel, input busy, done, q, r, dbz, ovf);
  modport slave  (input start, a, b, sel, output busy, done, q, r, dbz, ovf);
endinterface

// File: rtl/div_seq.sv
// Sequential restoring divider: 2*width-bit dividend by width-bit divisor,
// unsigned or signed (truncating), fixed width+2 cycle latency.
module div_seq #(
  parameter int width = 6
) (
  input logic      clk,
  input logic      rst,
  div_seq_if.slave bus
);

  localparam int cw = (width > 2) ? $clog2(width) : 1;
  localparam logic [cw-1:0]      cnt_one  = cw'(1);
  localparam logic [cw-1:0]      cnt_init = cw'(width - 1);
  localparam logic [width-1:0]   one_w    = width'(1);
  localparam logic [2*width-1:0] one_a    = (2*width)'(1);
  localparam logic [width-1:0]   ones_w   = {width{1'b1}};
  localparam logic [width-1:0]   zero_w   = {width{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state_r;
  logic [cw-1:0]     cnt_r;
  logic [width-1:0]  rem_r;
  logic [width-1:0]  sh_r;
  logic [width-1:0]  ub_r;
  logic [width-1:0]  alo_r;
  logic              sel_r;
  logic              sa_r;
  logic              sb_r;
  logic              dbz_r;
  logic              ovfhi_r;

  logic [2*width-1:0] ua_s;
  logic [width-1:0]   ub_s;
  logic [width:0]     trial_s;
  logic               fit_s;
  logic               neg_s;
  logic               ovfraw_s;
  logic [width-1:0]   qfix_s;
  logic [width-1:0]   rfix_s;
  logic               ovffix_s;

  // Operand magnitudes and the per-step trial compare of the restoring loop.
  always_comb begin
    ua_s = bus.a;
    ub_s = bus.b;
    if (bus.sel && bus.a[2*width-1]) begin
      ua_s = ~bus.a + one_a;
    end else begin
      ua_s = bus.a;
    end
    if (bus.sel && bus.b[width-1]) begin
      ub_s = ~bus.b + one_w;
    end else begin
      ub_s = bus.b;
    end
    trial_s = {rem_r, sh_r[width-1]};
    fit_s   = (trial_s >= {1'b0, ub_r});
  end

  // Sign correction and flag resolution applied in the FIX cycle.
  always_comb begin
    neg_s    = sa_r ^ sb_r;
    ovfraw_s = 1'b0;
    qfix_s   = sh_r;
    rfix_s   = rem_r;
    ovffix_s = 1'b0;
    // A negative result may reach 2^(width-1); a positive one stops one short.
    if (!sel_r) begin
      ovfraw_s = ovfhi_r;
    end else if (ovfhi_r) begin
      ovfraw_s = 1'b1;
    end else if (neg_s) begin
      ovfraw_s = sh_r[width-1] && (|sh_r[width-2:0]);
    end else begin
      ovfraw_s = sh_r[width-1];
    end
    if (dbz_r) begin
      qfix_s   = ones_w;
      rfix_s   = alo_r;
      ovffix_s = 1'b0;
    end else if (ovfraw_s) begin
      qfix_s   = ones_w;
      rfix_s   = zero_w;
      ovffix_s = 1'b1;
    end else begin
      qfix_s   = neg_s ? (~sh_r + one_w) : sh_r;
      rfix_s   = sa_r ? (~rem_r + one_w) : rem_r;
      ovffix_s = 1'b0;
    end
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= {cw{1'b0}};
      rem_r    <= zero_w;
      sh_r     <= zero_w;
      ub_r     <= zero_w;
      alo_r    <= zero_w;
      sel_r    <= 1'b0;
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      dbz_r    <= 1'b0;
      ovfhi_r  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.q    <= zero_w;
      bus.r    <= zero_w;
      bus.dbz  <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            sel_r    <= bus.sel;
            sa_r     <= bus.sel & bus.a[2*width-1];
            sb_r     <= bus.sel & bus.b[width-1];
            rem_r    <= ua_s[2*width-1:width];
            sh_r     <= ua_s[width-1:0];
            ub_r     <= ub_s;
            alo_r    <= bus.a[width-1:0];
            dbz_r    <= (bus.b == zero_w);
            ovfhi_r  <= (ua_s[2*width-1:width] >= ub_s);
            cnt_r    <= cnt_init;
            bus.busy <= 1'b1;
            state_r  <= CALC;
          end
        end
        CALC: begin
          rem_r <= fit_s ? (trial_s[width-1:0] - ub_r) : trial_s[width-1:0];
          sh_r  <= {sh_r[width-2:0], fit_s};
          if (cnt_r == {cw{1'b0}}) begin
            state_r <= FIX;
          end else begin
            cnt_r <= cnt_r - cnt_one;
          end
        end
        FIX: begin
          bus.q    <= qfix_s;
          bus.r    <= rfix_s;
          bus.dbz  <= dbz_r;
          bus.ovf  <= ovffix_s;
          bus.done <= 1'b1;
          state_r  <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed and random divides compared
// against an integer-arithmetic reference, plus handshake and reset checks.
module tb_div_seq;
  localparam int W = 6;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  div_seq_if #(.width(W)) bus();
  div_seq #(.width(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Truncating division on plain integers; range limits decide overflow.
  function automatic void model(input logic [2*W-1:0] a, input logic [W-1:0] b, input logic sel,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic dbz, output logic ovf);
    int av, bv, qt, rt;
    av  = sel ? int'($signed(a)) : int'(a);
    bv  = sel ? int'($signed(b)) : int'(b);
    dbz = 1'b0;
    ovf = 1'b0;
    q   = '0;
    r   = '0;
    if (bv == 0) begin
      dbz = 1'b1;
      q   = 6'h3F;
      r   = a[W-1:0];
    end else begin
      qt = av / bv;
      rt = av % bv;
      if (sel) ovf = (qt > 31) || (qt < -32);
      else     ovf = (qt > 63);
      if (ovf) begin
        q = 6'h3F;
        r = 6'h00;
      end else begin
        q = W'(qt);
        r = W'(rt);
      end
    end
  endfunction

  // One divide; poke >= 0 raises a stray start at that sample to prove it is ignored.
  task automatic run_div(input string tag, input logic [2*W-1:0] a, input logic [W-1:0] b,
                         input logic sel, input int poke);
    logic [W-1:0] eq, er, oq, orr;
    logic ed, eo, od, oo;
    int busy_n, done_n, done_k;
    busy_n = 0; done_n = 0; done_k = -1;
    oq = '0; orr = '0; od = 1'b0; oo = 1'b0;
    model(a, b, sel, eq, er, ed, eo);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sel = sel; bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start = 1'b0;
        bus.a     = 12'($urandom);
        bus.b     = 6'($urandom);
        bus.sel   = ~sel;
      end
      if (k == poke)     bus.start = 1'b1;
      if (k == poke + 1) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        done_k = k;
        oq = bus.q; orr = bus.r; od = bus.dbz; oo = bus.ovf;
      end
    end
    bus.start = 1'b0;
    chk({tag, ".busy_cycles"}, busy_n, 8);
    chk({tag, ".done_count"}, done_n, 1);
    chk({tag, ".done_edge"}, done_k + 1, W + 2);
    chk({tag, ".q"}, int'(oq), int'(eq));
    chk({tag, ".r"}, int'(orr), int'(er));
    chk({tag, ".dbz"}, int'(od), int'(ed));
    chk({tag, ".ovf"}, int'(oo), int'(eo));
    chk({tag, ".q_hold"}, int'(bus.q), int'(eq));
  endtask

  initial begin
    int dk[$];
    logic [W-1:0] eq, er;
    logic ed, eo;
    logic [2*W-1:0] ra;
    logic [W-1:0] rb;
    logic rs;

    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset.outputs", int'({bus.busy, bus.done, bus.q, bus.r, bus.dbz, bus.ovf}), 0);
    rst = 1'b0;
    @(negedge clk);

    run_div("unsigned_100_7", 12'd100, 6'd7, 1'b0, -1);
    run_div("signed_neg_a", 12'hF9C, 6'd7, 1'b1, -1);
    run_div("signed_neg_b", 12'd100, 6'h39, 1'b1, -1);
    run_div("signed_both_neg", 12'hF9C, 6'h39, 1'b1, -1);
    run_div("dbz", 12'h123, 6'd0, 1'b0, -1);
    run_div("dbz_signed", 12'hFC5, 6'd0, 1'b1, -1);
    run_div("ovf_unsigned", 12'd640, 6'd5, 1'b0, -1);
    run_div("ovf_signed_m32_m1", 12'hFE0, 6'h3F, 1'b1, -1);
    run_div("signed_m32_1", 12'hFE0, 6'd1, 1'b1, -1);
    run_div("signed_minb", 12'd100, 6'h20, 1'b1, -1);
    run_div("signed_mina_ovf", 12'h800, 6'h20, 1'b1, -1);
    run_div("unsigned_max_fit", 12'hFFF, 6'h3F, 1'b0, -1);
    run_div("start_pulse_c3", 12'd100, 6'd7, 1'b0, 2);
    run_div("start_in_done", 12'd200, 6'd9, 1'b0, 7);

    // Reset in the middle of a divide discards it.
    @(negedge clk);
    bus.a = 12'd500; bus.b = 6'd3; bus.sel = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.outputs", int'({bus.busy, bus.done, bus.q, bus.r, bus.dbz, bus.ovf}), 0);
    begin
      int dn;
      dn = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (bus.done) dn++;
      end
      chk("midrst.no_done", dn, 0);
    end
    rst = 1'b0;
    run_div("after_rst", 12'd1000, 6'd33, 1'b0, -1);

    // Held start: back-to-back divides, second accepted on the first IDLE edge.
    model(12'd77, 6'd5, 1'b0, eq, er, ed, eo);
    @(negedge clk);
    bus.a = 12'd77; bus.b = 6'd5; bus.sel = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 9) bus.start = 1'b0;
      if (bus.done) dk.push_back(k);
    end
    chk("held.done_count", dk.size(), 2);
    if (dk.size() == 2) begin
      chk("held.first_done", dk[0], 7);
      chk("held.second_done", dk[1], 16);
    end
    chk("held.q", int'(bus.q), int'(eq));
    chk("held.r", int'(bus.r), int'(er));

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      rb = 6'($urandom);
      if (i % 3 == 0) ra = 12'($urandom);
      else if (rs && (i % 2 == 0)) ra = 12'(-int'($urandom_range(0, 400)));
      else ra = 12'($urandom_range(0, 600));
      run_div($sformatf("rand%0d", i), ra, rb, rs, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Sequential restoring divider. It is the inverse companion of the combinational `mul` block.
- Divides a 2*width-bit dividend by a width-bit divisor and returns a width-bit quotient and a width-bit remainder.
- `sel` chooses unsigned (0) or two's-complement signed (1) operation.
- Uses a start/busy/done handshake so the arithmetic datapath can hand off long-latency divides without stalling the combinational multiply path.

Parameters:
- width, 6, operand width; dividend is width*2 bits, divisor/quotient/remainder are width bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request pulse; sampled only when idle.
- a  in  width*2  dividend; captured when start is accepted.
- b  in  width  divisor; captured when start is accepted.
- sel  in  1  0 = unsigned, 1 = signed; captured when start is accepted.
- busy  out  1  high from the cycle after acceptance through the done cycle, inclusive.
- done  out  1  one-cycle pulse; q/r/dbz/ovf are valid from this cycle onward.
- q  out  width  quotient.
- r  out  width  remainder.
- dbz  out  1  divide-by-zero flag.
- ovf  out  1  quotient-overflow flag.

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE. busy=0, done=0, q=0, r=0, dbz=0, ovf=0, iteration counter=0. An in-flight divide is discarded with no done pulse.

FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1: capture sel, a and b.
  - Form magnitudes: |a| (2*width bits) and |b| (width bits). When sel=0 the magnitudes are the raw values.
  - Record the sign of a and the sign of b.
  - Load the partial remainder with the upper half of |a| and the shift register with the lower half.
  - Set the counter to width-1, go to CALC.
- CALC, one quotient bit per cycle, MSB first:
  - Shift {partial remainder, shift reg} left by 1.
  - Compare the (width+1)-bit partial remainder against |b|. If ≥, subtract and set the quotient LSB to 1.
  - After width iterations (counter reaches 0), go to FIX.
- FIX, one cycle:
  - Apply signs when sel=1: quotient is negated if sign(a)≠sign(b); remainder takes the sign of the dividend (truncating division, so a = q*b + r).
  - Evaluate flags, register the outputs, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. q/r/flags hold until the next accepted start.

Latency:
- Fixed. done is high on the width+2'th rising edge after the edge that sampled start.
- width=6: 8 edges. The done cycle has no dependence on operand values.

Handshake:
- start is ignored while busy=1, including in the DONE cycle.
- a/b/sel may change after acceptance without effect.
- start may be held high: the next divide is accepted on the first IDLE cycle.

Flags (evaluated in FIX; the full fixed latency always runs):
- dbz: set when b==0. Then q=all ones, r=a[width-1:0], ovf=0.
- ovf, unsigned: set when a[2w-1:w] ≥ b, with b≠0.
- ovf, signed: set when the upper half of |a| ≥ |b|, or when the signed quotient magnitude exceeds the range. The range is 2^(w-1)-1 for a positive result and 2^(w-1) for a negative result.
- When ovf=1: q=all ones, r=0.
- dbz and ovf are never both 1.

Arithmetic:
- Magnitude of the most-negative value is taken in unsigned form, one bit wider internally.
- Example: b=-32 gives |b|=32 for width 6.
- No combinational path from inputs to outputs.

Test Plan (width=6):
- Unsigned: sel=0, a=100, b=7 → on edge 8: done=1, q=14, r=2, dbz=0, ovf=0. busy=1 for 8 cycles.
- Signed, negative dividend: sel=1, a=12'hF9C (-100), b=7 → q=6'h32 (-14), r=6'h3E (-2).
- Signed, negative divisor: sel=1, a=100, b=6'h39 (-7) → q=-14 (6'h32), r=2.
- Divide by zero: a=12'h123, b=0, sel=0 → dbz=1, ovf=0, q=6'h3F, r=6'h23, still on edge 8.
- Overflow:
  - sel=0, a=640, b=5 → ovf=1, q=6'h3F, r=0.
  - sel=1, a=12'hFE0 (-32), b=6'h3F (-1) → ovf=1.
  - sel=1, a=12'hFE0, b=1 → ovf=0, q=6'h20.
- Control:
  - start pulsed again at cycle 3 of a divide → ignored; a single done at edge 8 with the first operands.
  - rst asserted at cycle 4 → outputs 0 immediately, no done.
  - A new divide after rst release completes normally.
